// File: rtl/exc_irq_ctrl.sv
// exc_irq_ctrl: exception/interrupt controller for the LEGv8 core.
// Edge-latches N_IRQ external lines plus the decoder's invalid-opcode flag,
// presents one prioritised request (exc/estatus) until exc_ack, then tracks
// the handler until eret and pulses a per-channel acknowledge.
// Optional build macro: EXC_IRQ_MASK_EN adds a writable per-channel enable mask.
module exc_irq_ctrl #(
   parameter int N_IRQ = 4,
   parameter int ESW   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq,
   input  logic             not_an_instr,
   input  logic             eret,
   input  logic             exc_ack,
`ifdef EXC_IRQ_MASK_EN
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_wdata,
   output logic [N_IRQ-1:0] irq_mask,
`endif
   output logic             exc,
   output logic [ESW-1:0]   estatus,
   output logic [N_IRQ-1:0] ext_iack,
   output logic             busy,
   output logic             double_fault
);

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_BUSY} state_t;

   state_t           state_q, state_d;
   logic [N_IRQ-1:0] irq_q, irq_d;
   logic [N_IRQ-1:0] pending_q, pending_d;
   logic             exc_q, exc_d;
   logic [ESW-1:0]   estatus_q, estatus_d;
   logic [N_IRQ-1:0] iack_q, iack_d;
   logic             busy_q, busy_d;
   logic             dfault_q, dfault_d;
   logic [N_IRQ-1:0] mask_eff;

   logic [N_IRQ-1:0] rise;
   logic [N_IRQ-1:0] enabled;
   logic [N_IRQ-1:0] ack_onehot;
   logic [N_IRQ-1:0] pend_clr;
   logic             win_valid;
   logic [ESW-1:0]   win_code;

`ifdef EXC_IRQ_MASK_EN
   logic [N_IRQ-1:0] mask_q, mask_d;

   // Mask register: software write takes effect on the next edge
   always_comb begin
      mask_d = mask_q;
      if (mask_we) mask_d = mask_wdata;
   end

   assign mask_eff = mask_q;
   assign irq_mask = mask_q;
`else
   assign mask_eff = '1;
`endif

   // Winner selection: invalid opcode first, then lowest-index enabled pending line
   always_comb begin
      rise      = irq & ~irq_q;
      enabled   = pending_q & mask_eff;
      win_valid = 1'b0;
      win_code  = '0;
      if (not_an_instr) begin
         win_valid = 1'b1;
         win_code  = ESW'(1);
      end else begin
         for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (enabled[k]) begin
               win_valid = 1'b1;
               win_code  = ESW'(k + 2);
            end
         end
      end
      // Channel owning the latched cause (all zero for the instruction cause)
      for (int k = 0; k < N_IRQ; k++) begin
         ack_onehot[k] = (estatus_q == ESW'(k + 2));
      end
   end

   // Handshake FSM and next-state of the request/status registers
   always_comb begin
      state_d   = state_q;
      exc_d     = exc_q;
      estatus_d = estatus_q;
      iack_d    = '0;
      busy_d    = busy_q;
      dfault_d  = dfault_q;
      pend_clr  = '0;
      case (state_q)
         S_IDLE: begin
            if (win_valid) begin
               state_d   = S_PEND;
               exc_d     = 1'b1;
               estatus_d = win_code;
            end
         end
         S_PEND: begin
            if (not_an_instr) dfault_d = 1'b1;
            if (exc_ack) begin
               state_d  = S_BUSY;
               exc_d    = 1'b0;
               busy_d   = 1'b1;
               iack_d   = ack_onehot;
               pend_clr = ack_onehot;
            end
         end
         S_BUSY: begin
            if (not_an_instr) dfault_d = 1'b1;
            if (eret) begin
               state_d   = S_IDLE;
               busy_d    = 1'b0;
               estatus_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A fresh edge on the channel being acknowledged keeps it pending
      pending_d = (pending_q & ~pend_clr) | rise;
      irq_d     = irq;
   end

   // State registers; reset clears everything including an in-flight handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         irq_q     <= '0;
         pending_q <= '0;
         exc_q     <= 1'b0;
         estatus_q <= '0;
         iack_q    <= '0;
         busy_q    <= 1'b0;
         dfault_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         irq_q     <= irq_d;
         pending_q <= pending_d;
         exc_q     <= exc_d;
         estatus_q <= estatus_d;
         iack_q    <= iack_d;
         busy_q    <= busy_d;
         dfault_q  <= dfault_d;
      end
   end

`ifdef EXC_IRQ_MASK_EN
   // Mask resets to all channels enabled
   always_ff @(posedge clk) begin
      if (reset) mask_q <= '1;
      else       mask_q <= mask_d;
   end
`endif

   assign exc          = exc_q;
   assign estatus      = estatus_q;
   assign ext_iack     = iack_q;
   assign busy         = busy_q;
   assign double_fault = dfault_q;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Testbench for exc_irq_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_exc_irq_ctrl;

   localparam int N_IRQ = 4;
   localparam int ESW   = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [N_IRQ-1:0] irq;
   logic             not_an_instr;
   logic             eret;
   logic             exc_ack;
   logic             exc;
   logic [ESW-1:0]   estatus;
   logic [N_IRQ-1:0] ext_iack;
   logic             busy;
   logic             double_fault;
`ifdef EXC_IRQ_MASK_EN
   logic             mask_we;
   logic [N_IRQ-1:0] mask_wdata;
   logic [N_IRQ-1:0] irq_mask;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   // Behavioural model: mode 0=idle, 1=request outstanding, 2=handler running
   int               m_mode;
   int               m_cause;
   int               m_iack;
   bit               m_df;
   bit [N_IRQ-1:0]   m_pend;
   bit [N_IRQ-1:0]   m_prev;
   bit [N_IRQ-1:0]   m_mask;

   exc_irq_ctrl #(.N_IRQ(N_IRQ), .ESW(ESW)) dut (
      .clk          (clk),
      .reset        (reset),
      .irq          (irq),
      .not_an_instr (not_an_instr),
      .eret         (eret),
      .exc_ack      (exc_ack),
`ifdef EXC_IRQ_MASK_EN
      .mask_we      (mask_we),
      .mask_wdata   (mask_wdata),
      .irq_mask     (irq_mask),
`endif
      .exc          (exc),
      .estatus      (estatus),
      .ext_iack     (ext_iack),
      .busy         (busy),
      .double_fault (double_fault)
   );

   always #5 clk = ~clk;

   // One clock edge: advance the model with the inputs seen at the edge
   task automatic step();
      int win;
      int ack_ch;
      bit [N_IRQ-1:0] old_pend;
      @(posedge clk);
      if (reset) begin
         m_mode = 0; m_cause = 0; m_iack = -1; m_df = 0;
         m_pend = '0; m_prev = '0; m_mask = '1;
      end else begin
         old_pend = m_pend;
         ack_ch   = -1;
         m_iack   = -1;
         win      = 0;
         if (not_an_instr) win = 1;
         else begin
            for (int k = 0; k < N_IRQ; k++)
               if (win == 0 && old_pend[k] && m_mask[k]) win = k + 2;
         end
         case (m_mode)
            0: if (win != 0) begin m_mode = 1; m_cause = win; end
            1: begin
               if (not_an_instr) m_df = 1;
               if (exc_ack) begin
                  m_mode = 2;
                  if (m_cause >= 2) begin ack_ch = m_cause - 2; m_iack = ack_ch; end
               end
            end
            default: begin
               if (not_an_instr) m_df = 1;
               if (eret) begin m_mode = 0; m_cause = 0; end
            end
         endcase
         for (int k = 0; k < N_IRQ; k++) begin
            if (k == ack_ch) m_pend[k] = 0;
            if (irq[k] && !m_prev[k]) m_pend[k] = 1;
            m_prev[k] = irq[k];
         end
`ifdef EXC_IRQ_MASK_EN
         if (mask_we) m_mask = mask_wdata;
`endif
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; irq = '0; not_an_instr = 1'b0; eret = 1'b0; exc_ack = 1'b0;
`ifdef EXC_IRQ_MASK_EN
      mask_we = 1'b0; mask_wdata = '0;
`endif
      step(); step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      step();
      n_assert++;
      if ({exc, estatus, ext_iack, busy, double_fault} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: exc=%b estatus=%0d iack=%b busy=%b df=%b, want all 0",
                  exc, estatus, ext_iack, busy, double_fault);
      end
`ifdef EXC_IRQ_MASK_EN
      n_assert++;
      if (irq_mask !== 4'b1111) begin
         n_fail++; $display("FAIL reset_mask: got %b want 1111", irq_mask);
      end
`endif
   endtask

   task automatic test_irq_basic();
      do_reset();
      irq = 4'b0100; step();
      n_assert++;
      if (exc !== 1'b0) begin n_fail++; $display("FAIL basic_lat1: exc=%b want 0", exc); end
      step();
      n_assert++;
      if ({exc, estatus} !== {1'b1, 4'd4}) begin
         n_fail++; $display("FAIL basic_req: exc=%b estatus=%0d want 1/4", exc, estatus);
      end
      step();
      exc_ack = 1'b1; step(); exc_ack = 1'b0;
      n_assert++;
      if ({ext_iack, busy, exc} !== {4'b0100, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL basic_ack: iack=%b busy=%b exc=%b want 0100/1/0", ext_iack, busy, exc);
      end
      step();
      n_assert++;
      if ({ext_iack, busy, estatus} !== {4'b0000, 1'b1, 4'd4}) begin
         n_fail++; $display("FAIL basic_pulse: iack=%b busy=%b estatus=%0d want 0000/1/4", ext_iack, busy, estatus);
      end
      eret = 1'b1; step(); eret = 1'b0; irq = '0;
      n_assert++;
      if ({busy, estatus, exc} !== {1'b0, 4'd0, 1'b0}) begin
         n_fail++; $display("FAIL basic_eret: busy=%b estatus=%0d exc=%b want 0/0/0", busy, estatus, exc);
      end
   endtask

   task automatic test_priority();
      do_reset();
      irq = 4'b1010; step(); step();
      n_assert++;
      if ({exc, estatus} !== {1'b1, 4'd3}) begin
         n_fail++; $display("FAIL prio_first: exc=%b estatus=%0d want 1/3", exc, estatus);
      end
      exc_ack = 1'b1; step(); exc_ack = 1'b0;
      n_assert++;
      if (ext_iack !== 4'b0010) begin n_fail++; $display("FAIL prio_ack1: iack=%b want 0010", ext_iack); end
      eret = 1'b1; step(); eret = 1'b0;
      n_assert++;
      if ({exc, busy} !== 2'b00) begin n_fail++; $display("FAIL prio_gap: exc=%b busy=%b want 0/0", exc, busy); end
      step();
      n_assert++;
      if ({exc, estatus} !== {1'b1, 4'd5}) begin
         n_fail++; $display("FAIL prio_second: exc=%b estatus=%0d want 1/5", exc, estatus);
      end
      exc_ack = 1'b1; step(); exc_ack = 1'b0;
      n_assert++;
      if (ext_iack !== 4'b1000) begin n_fail++; $display("FAIL prio_ack2: iack=%b want 1000", ext_iack); end
      eret = 1'b1; step(); eret = 1'b0; irq = '0;
   endtask

   task automatic test_instr_vs_irq();
      do_reset();
      irq = 4'b0001; not_an_instr = 1'b1; step(); not_an_instr = 1'b0;
      n_assert++;
      if ({exc, estatus} !== {1'b1, 4'd1}) begin
         n_fail++; $display("FAIL instr_req: exc=%b estatus=%0d want 1/1", exc, estatus);
      end
      exc_ack = 1'b1; step(); exc_ack = 1'b0;
      n_assert++;
      if ({ext_iack, busy} !== {4'b0000, 1'b1}) begin
         n_fail++; $display("FAIL instr_ack: iack=%b busy=%b want 0000/1", ext_iack, busy);
      end
      eret = 1'b1; step(); eret = 1'b0; step();
      n_assert++;
      if ({exc, estatus} !== {1'b1, 4'd2}) begin
         n_fail++; $display("FAIL instr_then_irq: exc=%b estatus=%0d want 1/2", exc, estatus);
      end
      exc_ack = 1'b1; step(); exc_ack = 1'b0;
      n_assert++;
      if (ext_iack !== 4'b0001) begin n_fail++; $display("FAIL instr_irq_ack: iack=%b want 0001", ext_iack); end
      eret = 1'b1; step(); eret = 1'b0; irq = '0;
   endtask

   task automatic test_double_fault();
      do_reset();
      not_an_instr = 1'b1; step(); not_an_instr = 1'b0;
      exc_ack = 1'b1; step(); exc_ack = 1'b0;
      not_an_instr = 1'b1; step(); not_an_instr = 1'b0;
      n_assert++;
      if ({double_fault, busy, exc} !== 3'b110) begin
         n_fail++; $display("FAIL df_set: df=%b busy=%b exc=%b want 1/1/0", double_fault, busy, exc);
      end
      eret = 1'b1; step(); eret = 1'b0; step();
      n_assert++;
      if ({double_fault, busy, exc} !== 3'b100) begin
         n_fail++; $display("FAIL df_sticky: df=%b busy=%b exc=%b want 1/0/0", double_fault, busy, exc);
      end
      do_reset();
      n_assert++;
      if (double_fault !== 1'b0) begin n_fail++; $display("FAIL df_clear: df=%b want 0", double_fault); end
   endtask

   task automatic test_reset_mid_pend();
      do_reset();
      irq = 4'b0010; step(); step();
      n_assert++;
      if (exc !== 1'b1) begin n_fail++; $display("FAIL rst_pend_pre: exc=%b want 1", exc); end
      reset = 1'b1; irq = '0; step(); reset = 1'b0;
      n_assert++;
      if ({exc, busy, estatus} !== {1'b0, 1'b0, 4'd0}) begin
         n_fail++; $display("FAIL rst_pend_abort: exc=%b busy=%b estatus=%0d want 0/0/0", exc, busy, estatus);
      end
      step(); step(); step();
      n_assert++;
      if (exc !== 1'b0) begin n_fail++; $display("FAIL rst_pend_lost: exc=%b want 0", exc); end
   endtask

`ifdef EXC_IRQ_MASK_EN
   task automatic test_mask();
      do_reset();
      mask_we = 1'b1; mask_wdata = 4'b1110; step(); mask_we = 1'b0;
      n_assert++;
      if (irq_mask !== 4'b1110) begin n_fail++; $display("FAIL mask_write: got %b want 1110", irq_mask); end
      irq = 4'b0001; step(); irq = '0; step(); step(); step();
      n_assert++;
      if (exc !== 1'b0) begin n_fail++; $display("FAIL mask_block: exc=%b want 0", exc); end
      mask_we = 1'b1; mask_wdata = 4'b1111; step(); mask_we = 1'b0;
      n_assert++;
      if (exc !== 1'b0) begin n_fail++; $display("FAIL mask_lat: exc=%b want 0", exc); end
      step();
      n_assert++;
      if ({exc, estatus} !== {1'b1, 4'd2}) begin
         n_fail++; $display("FAIL mask_release: exc=%b estatus=%0d want 1/2", exc, estatus);
      end
   endtask
`endif

   task automatic test_random();
      logic [N_IRQ-1:0] exp_iack;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < N_IRQ; k++)
            if ($urandom_range(7) == 0) irq[k] = ~irq[k];
         not_an_instr = ($urandom_range(39) == 0);
         exc_ack      = ($urandom_range(2) == 0);
         eret         = ($urandom_range(5) == 0);
         reset        = ($urandom_range(299) == 0);
`ifdef EXC_IRQ_MASK_EN
         mask_we      = ($urandom_range(19) == 0);
         mask_wdata   = N_IRQ'($urandom);
`endif
         step();
         exp_iack = '0;
         if (m_iack >= 0) exp_iack[m_iack] = 1'b1;
         n_assert++;
         if (exc !== (m_mode == 1)) begin
            n_fail++; $display("FAIL rnd_exc c=%0d: got %b want %b", c, exc, (m_mode == 1));
         end
         n_assert++;
         if (estatus !== ESW'(m_cause)) begin
            n_fail++; $display("FAIL rnd_estatus c=%0d: got %0d want %0d", c, estatus, m_cause);
         end
         n_assert++;
         if (ext_iack !== exp_iack) begin
            n_fail++; $display("FAIL rnd_iack c=%0d: got %b want %b", c, ext_iack, exp_iack);
         end
         n_assert++;
         if (busy !== (m_mode == 2)) begin
            n_fail++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, (m_mode == 2));
         end
         n_assert++;
         if (double_fault !== m_df) begin
            n_fail++; $display("FAIL rnd_df c=%0d: got %b want %b", c, double_fault, m_df);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_irq_basic();
      test_priority();
      test_instr_vs_irq();
      test_double_fault();
      test_reset_mid_pend();
`ifdef EXC_IRQ_MASK_EN
      test_mask();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
